// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared widths, size encoding, FSM states and request checking
package cpu_mem_pkg;
  localparam int BYTE_ADDR_W = 9;
  localparam int WORD_ADDR_W = 7;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
  typedef enum logic [2:0] {IDLE, LD_ADDR, LD_DATA, RMW_ADDR, RMW_MERGE, WR, ERR} state_e;
  function automatic logic req_error(input logic [1:0] size, input logic [1:0] lane);
    return size == SZ_RSVD || (size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU request/response and data-memory bus bundle
interface mem_access_ctrl_if;
  import cpu_mem_pkg::*;
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [1:0]             req_size;
  logic                   req_unsigned;
  logic [BYTE_ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0]      req_wdata;
  logic                   resp_valid;
  logic                   resp_err;
  logic [DATA_W-1:0]      resp_rdata;
  logic [WORD_ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0]      mem_write_data;
  logic                   mem_we2;
  logic [DATA_W-1:0]      mem_read_data;
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_address, mem_write_data, mem_we2
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_address, mem_write_data, mem_we2
  );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian load lane extraction/extension and store lane merge
module mem_lane_align
  import cpu_mem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] st_word
);
  logic [7:0]  b;
  logic [15:0] h;
  // Pick the addressed byte/half, extend it for loads, splice store data into the read word
  always_comb begin
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    ld_data = size == SZ_BYTE ? {{24{b[7] && !is_unsigned}}, b} :
              size == SZ_HALF ? {{16{h[15] && !is_unsigned}}, h} : rdata;
    st_word = rdata;
    if (size == SZ_BYTE) st_word[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (size == SZ_HALF) st_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding CPU load/store controller over a word-wide registered memory
module mem_access_ctrl
  import cpu_mem_pkg::*;
(
  input logic clk,
  input logic reset,
  mem_access_ctrl_if.slave bus
);
  state_e                 state, state_nxt;
  logic                   uns_q;
  logic [1:0]             size_q;
  logic [BYTE_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]      data_q, ld_data, st_word;
  logic                   accept;
  assign accept = bus.req_valid && bus.req_ready;
  mem_lane_align u_align (
    .size        (size_q),
    .is_unsigned (uns_q),
    .lane        (addr_q[1:0]),
    .rdata       (bus.mem_read_data),
    .wdata       (data_q),
    .ld_data     (ld_data),
    .st_word     (st_word)
  );
  // State and request registers; data_q holds store data, later replaced by the merged word
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      uns_q  <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        uns_q  <= bus.req_unsigned;
        size_q <= bus.req_size;
        addr_q <= bus.req_addr;
        data_q <= bus.req_wdata;
      end else if (state == RMW_MERGE) begin
        data_q <= st_word;
      end
    end
  end
  // Next state and decoded outputs; reset masks every externally visible strobe
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (accept) state_nxt = req_error(bus.req_size, bus.req_addr[1:0]) ? ERR :
                                         !bus.req_we ? LD_ADDR :
                                         bus.req_size == SZ_WORD ? WR : RMW_ADDR;
      LD_ADDR:   state_nxt = LD_DATA;
      RMW_ADDR:  state_nxt = RMW_MERGE;
      RMW_MERGE: state_nxt = WR;
      default:   state_nxt = IDLE;
    endcase
    bus.req_ready      = !reset && state == IDLE;
    bus.resp_valid     = !reset && (state == LD_DATA || state == WR || state == ERR);
    bus.resp_err       = !reset && state == ERR;
    bus.resp_rdata     = (!reset && state == LD_DATA) ? ld_data : '0;
    bus.mem_we2        = !reset && state == WR;
    bus.mem_address    = reset ? '0 : addr_q[BYTE_ADDR_W-1:2];
    bus.mem_write_data = (!reset && state == WR) ? data_q : '0;
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed bench with a transaction-level memory model and per-cycle compare
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  mem_access_ctrl_if bus ();
  mem_access_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  logic [31:0] mem [128] = '{default: 32'h0};
  logic [31:0] ref_mem [128] = '{default: 32'h0};
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  bit running = 1'b1;
  bit busy = 1'b0;
  int exp_at;
  bit exp_err, exp_wr;
  logic [31:0] exp_rdata, exp_wdata;
  logic [6:0] exp_addr;
  logic [31:0] cap_rdata, cap_wdata;
  logic cap_err;

  // Registered-read data memory that the controller talks to
  always @(posedge clk) begin
    if (bus.mem_we2) mem[bus.mem_address] <= bus.mem_write_data;
    else bus.mem_read_data <= mem[bus.mem_address];
  end

  // Edge counter used to schedule expected responses
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: strobes must match the model schedule; payloads checked on the response cycle
  always @(negedge clk) if (running) begin
    bit exp_v;
    exp_v = busy && cyc == exp_at;
    chk("resp_valid", bus.resp_valid, exp_v);
    chk("mem_we2", bus.mem_we2, exp_v && exp_wr);
    chk("req_ready", bus.req_ready, !reset && !busy);
    if (reset) begin
      chk("rst_resp_err", bus.resp_err, 0);
      chk("rst_resp_rdata", bus.resp_rdata, 0);
      chk("rst_mem_address", bus.mem_address, 0);
      chk("rst_mem_write_data", bus.mem_write_data, 0);
    end
    if (exp_v) begin
      chk("resp_err", bus.resp_err, exp_err);
      chk("resp_rdata", bus.resp_rdata, exp_rdata);
      if (exp_wr) begin
        chk("mem_address", bus.mem_address, exp_addr);
        chk("mem_write_data", bus.mem_write_data, exp_wdata);
      end
      cap_rdata = bus.resp_rdata;
      cap_wdata = bus.mem_write_data;
      cap_err = bus.resp_err;
      busy = 1'b0;
    end
  end

  // lit_kind: 0 none, 1 load data, 2 written word, 3 error flag; abort_at>0 resets that many edges after accept
  task automatic do_req(input bit we, input bit [1:0] sz, input bit uns, input bit [8:0] a,
                        input bit [31:0] wd, input int lit_kind, input bit [31:0] lit, input int abort_at);
    int nb, bits, sh, lat, n;
    bit err;
    logic [31:0] old;
    longint unsigned m, v;
    nb = 1 << sz;
    err = sz == 2'd3 || (int'(a) % nb) != 0;
    bits = 8 * nb;
    sh = 8 * (int'(a) % 4);
    old = ref_mem[a / 4];
    m = (64'd1 << bits) - 1;
    exp_err = err;
    exp_wr = 1'b0;
    exp_rdata = 32'h0;
    exp_wdata = 32'h0;
    exp_addr = 7'(a / 4);
    if (err) lat = 1;
    else if (we) begin
      exp_wr = 1'b1;
      exp_wdata = (old & ~32'(m << sh)) | ((wd << sh) & 32'(m << sh));
      ref_mem[a / 4] = exp_wdata;
      lat = nb == 4 ? 1 : 3;
    end else begin
      v = (64'(old) >> sh) & m;
      if (!uns && v[bits-1]) v = v | ~m;
      exp_rdata = v[31:0];
      lat = 2;
    end
    exp_at = cyc + lat;
    cap_rdata = 32'h5A5A_5A5A;
    cap_wdata = 32'h5A5A_5A5A;
    cap_err = 1'bx;
    bus.req_we = we;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = a;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    @(posedge clk);
    busy = 1'b1;
    #1 bus.req_valid = 1'b0;
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(posedge clk);
      #1 reset = 1'b1;
      busy = 1'b0;
      ref_mem[a / 4] = old;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    n = 0;
    while (busy && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      fails++;
      $display("FAIL timeout actual=no_response required=response addr=%h", a);
      busy = 1'b0;
    end
    #1;
    if (lit_kind == 1) chk("lit_rdata", cap_rdata, lit);
    else if (lit_kind == 2) chk("lit_wdata", cap_wdata, lit);
    else if (lit_kind == 3) chk("lit_err", cap_err, lit);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    do_req(1, 2'd2, 0, 9'h010, 32'hDEADBEEF, 2, 32'hDEADBEEF, 0);
    do_req(0, 2'd2, 0, 9'h010, 32'h0, 1, 32'hDEADBEEF, 0);
    do_req(1, 2'd2, 0, 9'h010, 32'h80FF7F01, 2, 32'h80FF7F01, 0);
    do_req(0, 2'd0, 0, 9'h013, 32'h0, 1, 32'hFFFFFF80, 0);
    do_req(0, 2'd0, 1, 9'h013, 32'h0, 1, 32'h00000080, 0);
    do_req(0, 2'd1, 0, 9'h012, 32'h0, 1, 32'hFFFF80FF, 0);
    do_req(0, 2'd1, 1, 9'h012, 32'h0, 1, 32'h000080FF, 0);
    do_req(0, 2'd0, 0, 9'h010, 32'h0, 1, 32'h00000001, 0);
    do_req(0, 2'd2, 1, 9'h010, 32'h0, 1, 32'h80FF7F01, 0);
    do_req(1, 2'd2, 0, 9'h010, 32'h11223344, 0, 32'h0, 0);
    do_req(1, 2'd0, 0, 9'h011, 32'h000000AA, 2, 32'h1122AA44, 0);
    do_req(1, 2'd1, 0, 9'h012, 32'h0000BEEF, 2, 32'hBEEFAA44, 0);
    do_req(0, 2'd2, 0, 9'h010, 32'h0, 1, 32'hBEEFAA44, 0);
    do_req(0, 2'd2, 0, 9'h012, 32'h0, 3, 32'h1, 0);
    do_req(0, 2'd1, 0, 9'h011, 32'h0, 3, 32'h1, 0);
    do_req(0, 2'd3, 0, 9'h010, 32'h0, 3, 32'h1, 0);
    do_req(1, 2'd3, 0, 9'h010, 32'hFFFFFFFF, 3, 32'h1, 0);
    do_req(1, 2'd2, 0, 9'h013, 32'hFFFFFFFF, 3, 32'h1, 0);
    do_req(1, 2'd1, 0, 9'h011, 32'hFFFFFFFF, 3, 32'h1, 0);
    do_req(0, 2'd2, 0, 9'h010, 32'h0, 1, 32'hBEEFAA44, 0);
    do_req(1, 2'd2, 0, 9'h1FC, 32'h7F8001FE, 0, 32'h0, 0);
    do_req(0, 2'd0, 0, 9'h1FC, 32'h0, 1, 32'hFFFFFFFE, 0);
    do_req(0, 2'd0, 1, 9'h1FD, 32'h0, 1, 32'h00000001, 0);
    do_req(0, 2'd1, 0, 9'h1FE, 32'h0, 1, 32'h00007F80, 0);
    do_req(0, 2'd1, 1, 9'h1FC, 32'h0, 1, 32'h000001FE, 0);
    do_req(1, 2'd0, 0, 9'h1FF, 32'h12345680, 2, 32'h808001FE, 0);
    do_req(1, 2'd1, 0, 9'h1FC, 32'hFFFF1234, 2, 32'h80801234, 0);
    do_req(0, 2'd0, 0, 9'h1FF, 32'h0, 1, 32'hFFFFFF80, 0);
    do_req(1, 2'd0, 0, 9'h010, 32'h00000055, 0, 32'h0, 2);
    do_req(0, 2'd2, 0, 9'h010, 32'h0, 1, 32'hBEEFAA44, 0);
    do_req(1, 2'd0, 0, 9'h010, 32'h00000066, 2, 32'hBEEFAA66, 0);
    repeat (2) @(posedge clk);
    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
